// File: rtl/dac714_serial_out.sv
// rtl/dac714_serial_out.sv - serialiser from ramp generator strobe/word to the DAC714 3-wire bus
//
// Purpose: edge-detects dac_strobe, captures dac_data and shifts it MSB-first
// on dac_sck/dac_sdi while dac_ncs is low, then pulses dac_nld and waits a gap
// before accepting the next frame.
// Optional feature macro: DAC714_PENDING_EN (one-word pending buffer).
//
// Ports:
//   clk          in   system clock, rising edge
//   nReset       in   synchronous reset, active low
//   dac_strobe   in   level from ramp generator, rising edge = new word
//   dac_data     in   signed word, sampled on the edge-detect cycle
//   dac_sck      out  serial clock, idle low
//   dac_sdi      out  serial data, MSB first, changes with sck falling
//   dac_ncs      out  frame select, low for the whole shift
//   dac_nld      out  DAC load, low pulse after the frame
//   busy         out  high from capture until the gap ends
//   xfer_done    out  one-clk pulse when dac_nld returns high
//   overrun_cnt  out  saturating count of strobes lost while busy
module dac714_serial_out #(
    parameter int DAC_WIDTH  = 16,
    parameter int CLK_DIV    = 4,
    parameter int LD_WIDTH   = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 dac_strobe,
    input  logic [DAC_WIDTH-1:0] dac_data,
    output logic                 dac_sck,
    output logic                 dac_sdi,
    output logic                 dac_ncs,
    output logic                 dac_nld,
    output logic                 busy,
    output logic                 xfer_done,
    output logic [7:0]           overrun_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD, S_GAP} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(2 * DAC_WIDTH - 1);
    localparam logic [15:0] LD_LAST   = 16'(LD_WIDTH - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   strb_q;
    logic                   strb_edge;
    logic                   lost_edge;
    logic [DAC_WIDTH-1:0]   shreg_q, shreg_d;
    logic [15:0]            cnt_q, cnt_d;     // divider in SHIFT, duration counter in LOAD/GAP
    logic [15:0]            half_q, half_d;   // SCK half-periods completed in this frame
    logic                   sck_d, ncs_d, nld_d, done_d;
    logic [7:0]             ovr_d;
    logic                   start;
    logic [DAC_WIDTH-1:0]   start_word;
`ifdef DAC714_PENDING_EN
    logic                   pend_valid_q, pend_valid_d;
    logic [DAC_WIDTH-1:0]   pend_q, pend_d;
`endif

    assign strb_edge = dac_strobe & ~strb_q;
    assign busy      = (state_q != S_IDLE);
    assign lost_edge = strb_edge & busy;
    // The shift register MSB is the bit on the wire; it only moves on sck falling.
    assign dac_sdi   = shreg_q[DAC_WIDTH-1];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        sck_d      = dac_sck;
        ncs_d      = dac_ncs;
        nld_d      = dac_nld;
        done_d     = 1'b0;
        ovr_d      = overrun_cnt;
        start      = 1'b0;
        start_word = dac_data;
`ifdef DAC714_PENDING_EN
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        // Newest word wins; only a word displaced from the buffer is lost.
        if (lost_edge) begin
            pend_d       = dac_data;
            pend_valid_d = 1'b1;
            if (pend_valid_q && overrun_cnt != 8'hFF)
                ovr_d = overrun_cnt + 8'd1;
        end
`else
        if (lost_edge && overrun_cnt != 8'hFF)
            ovr_d = overrun_cnt + 8'd1;
`endif

        case (state_q)
            S_IDLE: begin
                if (strb_edge)
                    start = 1'b1;
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = '0;
                    sck_d  = ~dac_sck;
                    half_d = half_q + 16'd1;
                    if (dac_sck) begin
                        if (half_q == HALF_LAST) begin
                            ncs_d   = 1'b1;
                            nld_d   = 1'b0;
                            half_d  = '0;
                            state_d = S_LOAD;
                        end else begin
                            shreg_d = {shreg_q[DAC_WIDTH-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOAD: begin
                if (cnt_q == LD_LAST) begin
                    cnt_d   = '0;
                    nld_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef DAC714_PENDING_EN
                    // An edge on the last gap cycle is newer than the buffer.
                    if (pend_valid_q || strb_edge) begin
                        start        = 1'b1;
                        start_word   = strb_edge ? dac_data : pend_q;
                        pend_valid_d = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d = S_SHIFT;
            shreg_d = start_word;
            ncs_d   = 1'b0;
            sck_d   = 1'b0;
            cnt_d   = '0;
            half_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            strb_q      <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            half_q      <= '0;
            dac_sck     <= 1'b0;
            dac_ncs     <= 1'b1;
            dac_nld     <= 1'b1;
            xfer_done   <= 1'b0;
            overrun_cnt <= '0;
`ifdef DAC714_PENDING_EN
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            strb_q      <= dac_strobe;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            dac_sck     <= sck_d;
            dac_ncs     <= ncs_d;
            dac_nld     <= nld_d;
            xfer_done   <= done_d;
            overrun_cnt <= ovr_d;
`ifdef DAC714_PENDING_EN
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
`endif
        end
    end

endmodule
